// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared helpers for the serial sequence detector.
// State width, default pattern and the elaboration-time KMP next-state function.
package moore_seq_pkg;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  // Bits needed to encode states S0..Sn.
  function automatic int state_w(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 6; i++)
      if ((1 << w) < n + 1) w++;
    return w;
  endfunction

  // Next state from Sk on bit b for a len-bit pattern (first bit at MSB).
  // Pattern bit i is pat[len-1-i]. Returns the longest prefix of the
  // pattern that is a suffix of the consumed bits followed by b.
  // Without overlap, the full-match state restarts as S0.
  function automatic int next_state(
    input logic [15:0] pat,
    input int          len,
    input int          k,
    input logic        b,
    input bit          ovl
  );
    logic [16:0] s;
    int          kk;
    int          res;
    bit          ok;
    kk = (k >= len && !ovl) ? 0 : k;
    s  = '0;
    for (int i = 0; i < 17; i++) begin
      if (i < kk) s[i] = pat[len-1-i];
      else if (i == kk) s[i] = b;
    end
    res = 0;
    for (int j = 1; j < 17; j++) begin
      if (j <= kk + 1 && j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < j) begin
            if (pat[len-1-i] != s[kk+1-j+i]) ok = 1'b0;
          end
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/moore_match_counter.sv
// moore_match_counter: saturating match counter with increment and hold.
// Synchronous active-low reset; never wraps past all-ones.
module moore_match_counter
  import moore_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Increment on a hit unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: parametrised Moore sequence detector with stall input.
// Define MOORE_SEQ_CNT_EN to build the saturating match counter.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEF_PATTERN),
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  localparam int          SW    = state_w(PATTERN_LEN);
  localparam int          NS    = 1 << SW;
  localparam logic [15:0] PAT16 = 16'(PATTERN);

  typedef enum logic [SW-1:0] {
    S0 = '0,
    SN = SW'(PATTERN_LEN)
  } state_e;

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  // Transition table; unreachable encodings recover to S0.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam int N0 = (k <= PATTERN_LEN) ?
      next_state(PAT16, PATTERN_LEN, k, 1'b0, OVERLAP) : 0;
    localparam int N1 = (k <= PATTERN_LEN) ?
      next_state(PAT16, PATTERN_LEN, k, 1'b1, OVERLAP) : 0;
    assign nxt0[k] = SW'(N0);
    assign nxt1[k] = SW'(N1);
  end

  state_e state_q, state_d;

  // Next state on consumed bits; Moore output from current state.
  always_comb begin
    state_d = state_q;
    z       = (state_q == SN);
    if (en)
      state_d = state_e'(x ? nxt1[state_q] : nxt0[state_q]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

`ifdef MOORE_SEQ_CNT_EN
  logic hit;
  assign hit = en && (state_d == SN);

  moore_match_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i (clk),
    .rst_ni(rst),
    .inc_i (hit),
    .cnt_o (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: directed tests for moore_seq_detector variants.
// Four configurations share one stimulus stream.
module tb_moore_seq_detector;

`ifdef MOORE_SEQ_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic x   = 1'b0;

  logic       z_def, z_nov, z_c2, z_one;
  logic [7:0] c_def, c_nov, c_one;
  logic [1:0] c_c2;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  moore_seq_detector u_def (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .z(z_def), .match_count(c_def)
  );

  moore_seq_detector #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .z(z_nov), .match_count(c_nov)
  );

  moore_seq_detector #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .z(z_c2), .match_count(c_c2)
  );

  moore_seq_detector #(.PATTERN(4'b1111)) u_one (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .z(z_one), .match_count(c_one)
  );

  function automatic int ec(input int n);
    return CNT_ON ? n : 0;
  endfunction

  task automatic step(input logic xv, input logic ev);
    x  = xv;
    en = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b1, 1'b1);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    ntot++;
    if (z_def !== 1'b0) $display("FAIL reset_z got %b want 0", z_def);
    else npass++;
    ntot++;
    if (c_def !== 8'd0) $display("FAIL reset_cnt got %0d want 0", c_def);
    else npass++;
    ntot++;
    if (z_one !== 1'b0) $display("FAIL reset_z_ones got %b want 0", z_one);
    else npass++;
  endtask

  task automatic test_overlap();
    logic [6:0] xs;
    logic [6:0] zd;
    logic [6:0] zn;
    xs = 7'b1011011;
    zd = 7'b0001001;
    zn = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(xs[6-i], 1'b1);
      ntot++;
      if (z_def !== zd[6-i])
        $display("FAIL ovl_z edge %0d got %b want %b", i + 1, z_def, zd[6-i]);
      else npass++;
      ntot++;
      if (z_nov !== zn[6-i])
        $display("FAIL novl_z edge %0d got %b want %b", i + 1, z_nov, zn[6-i]);
      else npass++;
    end
    ntot++;
    if (int'(c_def) !== ec(2))
      $display("FAIL ovl_cnt got %0d want %0d", c_def, ec(2));
    else npass++;
    ntot++;
    if (int'(c_nov) !== ec(1))
      $display("FAIL novl_cnt got %0d want %0d", c_nov, ec(1));
    else npass++;
  endtask

  task automatic test_stall();
    logic [2:0] sx;
    sx = 3'b010;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(sx[i], 1'b0);
      ntot++;
      if (z_def !== 1'b0) $display("FAIL stall_z %0d got %b want 0", i, z_def);
      else npass++;
    end
    step(1'b1, 1'b1);
    ntot++;
    if (z_def !== 1'b1) $display("FAIL stall_rise got %b want 1", z_def);
    else npass++;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      ntot++;
      if (z_def !== 1'b1) $display("FAIL stall_hold %0d got %b want 1", i, z_def);
      else npass++;
      ntot++;
      if (int'(c_def) !== ec(1))
        $display("FAIL stall_cnt %0d got %0d want %0d", i, c_def, ec(1));
      else npass++;
    end
    step(1'b0, 1'b1);
    ntot++;
    if (z_def !== 1'b0) $display("FAIL stall_fall got %b want 0", z_def);
    else npass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b0;
    step(1'b1, 1'b1);
    ntot++;
    if (z_def !== 1'b0) $display("FAIL midrst_z got %b want 0", z_def);
    else npass++;
    ntot++;
    if (c_def !== 8'd0) $display("FAIL midrst_cnt got %0d want 0", c_def);
    else npass++;
    rst = 1'b1;
    step(1'b1, 1'b1);
    ntot++;
    if (z_def !== 1'b0) $display("FAIL midrst_first got %b want 0", z_def);
    else npass++;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    ntot++;
    if (z_def !== 1'b1) $display("FAIL midrst_fresh got %b want 1", z_def);
    else npass++;
    ntot++;
    if (int'(c_def) !== ec(1))
      $display("FAIL midrst_fresh_cnt got %0d want %0d", c_def, ec(1));
    else npass++;
  endtask

  task automatic test_saturate();
    int m;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    ntot++;
    if (int'(c_c2) !== ec(1))
      $display("FAIL sat_cnt m1 got %0d want %0d", c_c2, ec(1));
    else npass++;
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      m = (i > 3) ? 3 : i;
      ntot++;
      if (int'(c_c2) !== ec(m))
        $display("FAIL sat_cnt m%0d got %0d want %0d", i, c_c2, ec(m));
      else npass++;
      ntot++;
      if (z_c2 !== 1'b1) $display("FAIL sat_z m%0d got %b want 1", i, z_c2);
      else npass++;
    end
    ntot++;
    if (int'(c_def) !== ec(5))
      $display("FAIL sat_wide_cnt got %0d want %0d", c_def, ec(5));
    else npass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] zo;
    zo = 6'b000111;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      ntot++;
      if (z_one !== zo[5-i])
        $display("FAIL b2b_z edge %0d got %b want %b", i + 1, z_one, zo[5-i]);
      else npass++;
      ntot++;
      if (z_def !== 1'b0)
        $display("FAIL b2b_def_z edge %0d got %b want 0", i + 1, z_def);
      else npass++;
    end
    ntot++;
    if (int'(c_one) !== ec(3))
      $display("FAIL b2b_cnt got %0d want %0d", c_one, ec(3));
    else npass++;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_stall();
    test_mid_reset();
    test_saturate();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
